booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Iterative signed radix-4 Booth multiplier core for the NPU MAC datapath.
- Sits directly downstream of the Modified Booth Encoder. It scans the multiplier in overlapping 3-bit windows, drives each window to the encoder, and consumes the returned {sign, mult, zero} code.
- Each code selects a partial product, which is accumulated one window per clock.
- The full product is returned with a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4. Operands are two's complement.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  signed multiplicand; captured on accepted start.
- b  input  WIDTH  signed multiplier; captured on accepted start.
- win_o  output  3  current Booth window {A,B,C} = {b[2i+1], b[2i], b[2i-1]}, to the encoder inputs.
- enc_i  input  3  encoder result. enc_i[2] = sign, enc_i[1] = mult (1 means x1), enc_i[0] = zero. Combinational return in the same cycle.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  signed result; held until the next done.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; acc, mreg, breg, cnt, product all 0; done=0; busy=0.
  - win_o=3'b000.
  - Reset asserted mid-operation aborts it immediately, with no done pulse.
- Internal registers:
  - mreg: 2*WIDTH-bit sign-extended a.
  - breg: WIDTH+1 bits, loaded with {b,1'b0}.
  - cnt: log2(WIDTH/2)+1 bits.
  - acc: 2*WIDTH bits.
- win_o = breg[2:0], purely combinational from breg.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1 at an edge, load mreg, breg, cnt=0, acc=0, then go to RUN. start=0 stays in IDLE.
  - RUN, on each edge:
    - Compute the partial product from enc_i:
      - zero=1: pp = 0. This overrides sign, so window 111 gives 0.
      - zero=0, mult=1: mag = mreg.
      - zero=0, mult=0: mag = mreg<<1.
      - pp = sign ? -mag : mag.
    - acc <= acc + (pp << 2*cnt).
    - breg <= breg >> 2 (arithmetic shift). cnt <= cnt+1.
    - When cnt == WIDTH/2-1: product <= acc + (pp << 2*cnt), then go to DONE.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- All arithmetic is modulo 2^(2*WIDTH). The exact signed product always fits, including (-2^(W-1))*(-2^(W-1)).
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH/2, i.e. WIDTH/2+1 cycles. Throughput is one product per WIDTH/2+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. a and b changing during RUN have no effect.
- product changes only on the RUN→DONE transition. It keeps its old value through a subsequent RUN.
- The block does not check enc_i consistency. It trusts the encoder code.

Test Plan:
1. WIDTH=8, reset, then start with a=3, b=5. Expect window sequence 010, 010, 000, 000; done pulse exactly 5 cycles after the start edge; product=16'd15; busy high 5 cycles.
2. a=7, b=-1. Every window is 111 (zero=1 with sign=1), except the first, 110 (-1). Expect product=-7 (16'hFFF9). Also confirm the zero override never adds -mreg.
3. Corner operands, back-to-back. Expect:
   - a=-128, b=-128 → product=16384.
   - a=-128, b=127 → -16256.
   - a=127, b=127 → 16129.
   - a=0, b=-77 → 0.
4. Start pulsed every cycle during RUN and DONE, with a/b changing. Expect only the first request computed; next start accepted only from IDLE; product reflects the captured operands.
5. Reset asserted asynchronously mid-edge-interval at cycle 2 of RUN. Expect immediate busy=0, done=0, product=0, win_o=000. A new start (a=-3, b=6) afterwards yields -18.
6. Random regression: 10k random signed pairs with the real encoder attached. Product must equal a*b, and done must be a single-cycle pulse every time.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier.
// Emits one Booth window per cycle and accumulates the encoder-selected partial product.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2:0]         win_o,
  input  logic [2:0]         enc_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] acc;
  logic [PW-1:0] mreg;
  logic [WIDTH:0] breg;
  logic [CW-1:0] cnt;

  logic [PW-1:0] mag;
  logic [PW-1:0] pp;
  logic [PW-1:0] term;

  assign win_o = breg[2:0];

  // zero wins over sign, so window 111 contributes nothing
  always_comb begin
    mag  = enc_i[1] ? mreg : {mreg[PW-2:0], 1'b0};
    pp   = '0;
    if (!enc_i[0]) begin
      pp = enc_i[2] ? (PW'(0) - mag) : mag;
    end
    term = pp << {cnt, 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mreg    <= '0;
      breg    <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mreg  <= {{WIDTH{a[WIDTH-1]}}, a};
            breg  <= {b, 1'b0};
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + term;
          breg <= {{2{breg[WIDTH]}}, breg[WIDTH:2]};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= acc + term;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult with a behavioural Booth encoder attached.
// Products are checked against plain signed integer multiplication.
module tb_booth_seq_mult;

  localparam int W = 8;
  localparam int LAT = W / 2 + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [2:0]      win;
  logic [2:0]      enc;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int checks = 0;
  int errors = 0;
  logic [2:0] wins [W/2];
  int bcnt;

  always #5 clk = ~clk;

  // radix-4 Booth table: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
  assign enc = {win[2], win[1] ^ win[0], (win == 3'b000) || (win == 3'b111)};

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .win_o   (win),
    .enc_i   (enc),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] x,
                                             input logic signed [W-1:0] y);
    int ix;
    int iy;
    ix = x;
    iy = y;
    return (2*W)'(ix * iy);
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string tag,
                        input bit full);
    int n;
    logic [2*W-1:0] e;
    e = ref_mul(ta, tb_);
    a = ta;
    b = tb_;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    bcnt = 0;
    while (!done && n < 20) begin
      if (n <= W / 2) wins[n-1] = win;
      if (busy) bcnt++;
      @(negedge clk);
      n++;
    end
    if (busy) bcnt++;
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_prod"}, 32'(product), 32'(e));
    @(negedge clk);
    check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    if (full) check({tag, "_busy"}, 32'(bcnt), 32'(LAT));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    int n;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    check("rst_state", {11'd0, busy, done, win, product}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 3 * 5
    run_op(8'd3, 8'd5, "t1", 1'b1);
    check("t1_w0", 32'(wins[0]), 32'(3'b010));
    check("t1_w1", 32'(wins[1]), 32'(3'b010));
    check("t1_w2", 32'(wins[2]), 32'(3'b000));
    check("t1_w3", 32'(wins[3]), 32'(3'b000));

    // 7 * -1 exercises the zero-over-sign window
    run_op(8'd7, 8'hFF, "t2", 1'b1);
    check("t2_w0", 32'(wins[0]), 32'(3'b110));
    check("t2_w1", 32'(wins[1]), 32'(3'b111));
    check("t2_w3", 32'(wins[3]), 32'(3'b111));
    check("t2_val", 32'(product), 32'(16'hFFF9));

    run_op(8'h80, 8'h80, "t3a", 1'b0);
    check("t3a_val", 32'(product), 32'(16'd16384));
    run_op(8'h80, 8'd127, "t3b", 1'b0);
    check("t3b_val", 32'(product), 32'(16'hC080));
    run_op(8'd127, 8'd127, "t3c", 1'b0);
    check("t3c_val", 32'(product), 32'(16'd16129));
    run_op(8'd0, 8'hB3, "t3d", 1'b0);

    // start held high through RUN/DONE with moving operands
    a = 8'd25;
    b = 8'hF7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (!done && n < 20) begin
      if (n == 2) check("t4_hold", 32'(product), 32'd0);
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      n++;
    end
    check("t4_lat", 32'(n), 32'(LAT));
    check("t4_prod", 32'(product), 32'(ref_mul(8'd25, 8'hF7)));
    ca = 8'hE5;
    cb = 8'd44;
    a = ca;
    b = cb;
    @(negedge clk);
    check("t4_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4b_lat", 32'(n), 32'(LAT));
    check("t4b_prod", 32'(product), 32'(ref_mul(ca, cb)));
    @(negedge clk);

    // async reset during the second RUN cycle
    a = 8'd100;
    b = 8'd99;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("t5_abort", {11'd0, busy, done, win, product}, 32'd0);
    @(negedge clk);
    check("t5_nodone", {31'd0, done}, 32'd0);
    rst = 1'b0;
    run_op(8'hFD, 8'd6, "t5", 1'b1);
    check("t5_val", 32'(product), 32'(16'hFFEE));

    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, "rnd", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
